// File: rtl/mysystem_done_seq_pkg.sv
// Shared types and constants for the done sequencer.
// FSM state, register addresses and STATUS/CONTROL bit positions.
package mysystem_done_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } seq_state_t;

   localparam logic [1:0] ADDR_STATUS  = 2'd0;
   localparam logic [1:0] ADDR_CONTROL = 2'd1;
   localparam logic [1:0] ADDR_TIMEOUT = 2'd2;
   localparam logic [1:0] ADDR_ELAPSED = 2'd3;

   localparam int ST_BUSY   = 0;
   localparam int ST_DONE   = 1;
   localparam int ST_TMO    = 2;
   localparam int ST_DONE_S = 3;

   localparam int CTL_START  = 0;
   localparam int CTL_ABORT  = 1;
   localparam int CTL_IRQ_EN = 2;

endpackage

// File: rtl/mysystem_done_sync.sv
// done_in conditioner plus rising-edge detector.
// Ports: clk, reset_n, done_in in; done_s (conditioned level), done_rise out.
// MYSYSTEM_DONE_SYNC_EN: 2-flop synchronizer, else a single register stage.
module mysystem_done_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic done_in,
   output logic done_s,
   output logic done_rise
);

   logic done_q;

`ifdef MYSYSTEM_DONE_SYNC_EN
   logic done_meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done_meta <= 1'b0;
         done_s    <= 1'b0;
      end else begin
         done_meta <= done_in;
         done_s    <= done_meta;
      end
   end
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) done_s <= 1'b0;
      else          done_s <= done_in;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) done_q <= 1'b0;
      else          done_q <= done_s;
   end

   assign done_rise = done_s & ~done_q;

endmodule

// File: rtl/mysystem_done_sequencer.sv
// Avalon-MM sequencer: START -> start_out pulse -> wait for done edge/timeout.
// Ports: clk, reset_n, address/write_n/writedata/chipselect/readdata (slave),
// start_out, done_in, irq. Optional macro: MYSYSTEM_DONE_SYNC_EN.
module mysystem_done_sequencer #(
   parameter int CNT_W     = 32,
   parameter int START_LEN = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        write_n,
   input  logic [31:0] writedata,
   input  logic        chipselect,
   output logic [31:0] readdata,
   output logic        start_out,
   input  logic        done_in,
   output logic        irq
);

   import mysystem_done_seq_pkg::*;

   localparam logic [3:0] LAUNCH_LAST = 4'(START_LEN - 1);

   seq_state_t       state;
   logic [3:0]       launch_cnt;
   logic [CNT_W-1:0] elapsed;
   logic [CNT_W-1:0] timeout;
   logic             irq_en;
   logic             done_sticky;
   logic             timeout_sticky;

   logic             done_s;
   logic             done_rise;
   logic             wr;
   logic             wr_stat;
   logic             wr_ctl;
   logic             wr_tmo;
   logic             start_req;
   logic             abort_req;
   logic [CNT_W:0]   elapsed_inc;
   logic             tmo_hit;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   mysystem_done_sync u_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .done_in   (done_in),
      .done_s    (done_s),
      .done_rise (done_rise)
   );

   assign wr        = chipselect & ~write_n;
   assign wr_stat   = wr & (address == ADDR_STATUS);
   assign wr_ctl    = wr & (address == ADDR_CONTROL);
   assign wr_tmo    = wr & (address == ADDR_TIMEOUT);
   assign start_req = wr_ctl & writedata[CTL_START];
   assign abort_req = wr_ctl & writedata[CTL_ABORT];

   assign unused_wdata = ^writedata;

   // Extra bit keeps the TIMEOUT compare exact even at all-ones.
   assign elapsed_inc = {1'b0, elapsed} + (CNT_W+1)'(1);
   assign tmo_hit     = (timeout != '0) &&
                        (elapsed_inc == {1'b0, timeout});

   always_comb begin
      rd_mux = '0;
      unique case (1'b1)
         (address == ADDR_STATUS): begin
            rd_mux[ST_BUSY]   = (state != IDLE);
            rd_mux[ST_DONE]   = done_sticky;
            rd_mux[ST_TMO]    = timeout_sticky;
            rd_mux[ST_DONE_S] = done_s;
         end
         (address == ADDR_CONTROL): rd_mux[CTL_IRQ_EN] = irq_en;
         (address == ADDR_TIMEOUT): rd_mux[CNT_W-1:0] = timeout;
         (address == ADDR_ELAPSED): rd_mux[CNT_W-1:0] = elapsed;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         launch_cnt     <= '0;
         elapsed        <= '0;
         timeout        <= '0;
         irq_en         <= 1'b0;
         done_sticky    <= 1'b0;
         timeout_sticky <= 1'b0;
         start_out      <= 1'b0;
         irq            <= 1'b0;
         readdata       <= '0;
      end else begin
         readdata <= rd_mux;
         irq      <= irq_en & (done_sticky | timeout_sticky);

         if (wr_tmo) timeout <= writedata[CNT_W-1:0];
         if (wr_ctl) irq_en  <= writedata[CTL_IRQ_EN];

         // W1C first; any set below in the same cycle overrides it.
         if (wr_stat && writedata[ST_DONE]) done_sticky    <= 1'b0;
         if (wr_stat && writedata[ST_TMO])  timeout_sticky <= 1'b0;

         unique case (state)
            IDLE: begin
               if (start_req && !abort_req) begin
                  state          <= LAUNCH;
                  launch_cnt     <= '0;
                  start_out      <= 1'b1;
                  elapsed        <= '0;
                  done_sticky    <= 1'b0;
                  timeout_sticky <= 1'b0;
               end
            end
            LAUNCH: begin
               if (abort_req) begin
                  state     <= IDLE;
                  start_out <= 1'b0;
               end else if (launch_cnt == LAUNCH_LAST) begin
                  state     <= WAIT;
                  start_out <= 1'b0;
               end else begin
                  launch_cnt <= launch_cnt + 4'd1;
               end
            end
            WAIT: begin
               if (abort_req) begin
                  state <= IDLE;
               end else begin
                  if (!(&elapsed)) elapsed <= elapsed_inc[CNT_W-1:0];
                  if (done_rise) begin
                     done_sticky <= 1'b1;
                     state       <= IDLE;
                  end else if (tmo_hit) begin
                     timeout_sticky <= 1'b1;
                     state          <= IDLE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               start_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
